code_gen: RTL and testbench

- Upstream reference-code source for the DSP correlator stage.
- Generates a maximal-length LFSR chip stream (`code`) at a programmable chip rate.
- Emits a one-cycle `capture` strobe at every code-epoch boundary, so the correlator latches its match/miss counts once per full code period.
- Provides a one-chip `slip` control for code-phase search, plus a synchronous `restart`.

---
 rtl/code_gen.sv | 102 ++++++++++
 tb/tb_code_gen.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/code_gen.sv
// code_gen: LFSR reference-code generator for the correlator stage.
// Produces the chip stream, the chip strobe, the epoch capture pulse and the chip/epoch counters.
// Ports: clk, rst (async, active-low), enable, restart, slip -> code, chip_strobe,
//        capture, chip_index, epoch_count, slip_busy.
module code_gen #(
    parameter int                  LFSR_LEN = 10,
    parameter logic [LFSR_LEN-1:0] TAPS     = 10'h204,
    parameter logic [LFSR_LEN-1:0] SEED     = 10'h3FF,
    parameter int                  CHIP_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                restart,
    input  logic                slip,
    output logic                code,
    output logic                chip_strobe,
    output logic                capture,
    output logic [LFSR_LEN-1:0] chip_index,
    output logic [7:0]          epoch_count,
    output logic                slip_busy
);

    localparam int DW = (CHIP_DIV > 1) ? $clog2(CHIP_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CHIP_DIV - 1);
    // Last chip index of an epoch: 2^LFSR_LEN - 2.
    localparam logic [LFSR_LEN-1:0] IDX_MAX = {{(LFSR_LEN-1){1'b1}}, 1'b0};

    logic [LFSR_LEN-1:0] lfsr_q, lfsr_d;
    logic [DW-1:0]       div_q, div_d;
    logic [LFSR_LEN-1:0] idx_q, idx_d;
    logic [7:0]          epoch_q, epoch_d;
    logic                cap_q, cap_d;
    logic                pend_q, pend_d;
    logic                strobe;

    assign strobe      = enable && (div_q == DIV_LAST);
    assign chip_strobe = strobe;
    assign code        = lfsr_q[LFSR_LEN-1];
    assign capture     = cap_q;
    assign chip_index  = idx_q;
    assign epoch_count = epoch_q;
    assign slip_busy   = pend_q;

    always_comb begin
        lfsr_d  = lfsr_q;
        div_d   = div_q;
        idx_d   = idx_q;
        epoch_d = epoch_q;
        pend_d  = pend_q;
        cap_d   = 1'b0;
        if (restart) begin
            lfsr_d  = SEED;
            div_d   = '0;
            idx_d   = '0;
            epoch_d = '0;
            pend_d  = 1'b0;
            cap_d   = 1'b1;
        end else if (enable) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (strobe) begin
                // A request landing on the strobe itself is served next chip.
                pend_d = slip;
                if (!pend_q) begin
                    lfsr_d = {lfsr_q[LFSR_LEN-2:0], ^(lfsr_q & TAPS)};
                    if (idx_q == IDX_MAX) begin
                        idx_d   = '0;
                        epoch_d = epoch_q + 8'd1;
                        cap_d   = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end else begin
                pend_d = pend_q | slip;
            end
        end
        // All-zero state would lock the register forever.
        if (!restart && lfsr_q == '0) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lfsr_q  <= SEED;
            div_q   <= '0;
            idx_q   <= '0;
            epoch_q <= '0;
            cap_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            epoch_q <= epoch_d;
            cap_q   <= cap_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_code_gen.sv
// tb_code_gen: directed self-checking bench for code_gen with default parameters.
// Steps: reset, free run, slips, enable gap, restart, async reset at capture.
`timescale 1ns/1ps
module tb_code_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       restart;
    logic       slip;
    logic       code;
    logic       chip_strobe;
    logic       capture;
    logic [9:0] chip_index;
    logic [7:0] epoch_count;
    logic       slip_busy;

    int n_vec = 0;
    int n_err = 0;
    int chips;
    int ones;
    int n;
    int bad;
    bit cur_seq [1023];
    bit prev_seq[1023];
    logic [9:0] idx_log[64];
    logic       f_code;
    logic [9:0] f_idx;
    logic [7:0] f_ep;
    logic       f_sb;

    code_gen dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .restart    (restart),
        .slip       (slip),
        .code       (code),
        .chip_strobe(chip_strobe),
        .capture    (capture),
        .chip_index (chip_index),
        .epoch_count(epoch_count),
        .slip_busy  (slip_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Samples on falling edges until capture; n counts rising edges passed.
    task automatic wait_cap(input int start, output int cnt);
        cnt   = start;
        chips = 0;
        ones  = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt < 64) idx_log[cnt] = chip_index;
            if (chip_strobe) begin
                if (chips < 1023) cur_seq[chips] = code;
                chips++;
                ones += int'(code);
            end
        end while (!capture && cnt < start + 6000);
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        restart = 1'b0;
        slip = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_code", code, 1);
        chk("rst_capture", capture, 0);
        chk("rst_index", chip_index, 0);
        chk("rst_epoch", epoch_count, 0);
        chk("rst_slip_busy", slip_busy, 0);
        chk("rst_strobe", chip_strobe, 0);

        // First epoch from reset release
        rst = 1'b1;
        enable = 1'b1;
        wait_cap(0, n);
        chk("first_cap_cycles", n, 4092);
        chk("first_cap_index", chip_index, 0);
        chk("first_cap_epoch", epoch_count, 1);
        chk("first_cap_code", code, 1);
        bad = 0;
        for (int i = 0; i < 10; i++) if (cur_seq[i] !== 1'b1) bad++;
        chk("first10_ones", bad, 0);
        bad = 0;
        for (int k = 1; k <= 40; k++) if (idx_log[k] !== 10'(k / 4)) bad++;
        chk("chip_len4", bad, 0);
        chk("epoch1_ones", ones, 512);
        prev_seq = cur_seq;

        // Free-running epochs
        wait_cap(0, n);
        chk("epoch2_cycles", n, 4092);
        chk("epoch2_ones", ones, 512);
        bad = 0;
        for (int i = 0; i < 1023; i++) if (cur_seq[i] !== prev_seq[i]) bad++;
        chk("epoch2_repeat", bad, 0);
        prev_seq = cur_seq;
        wait_cap(0, n);
        chk("epoch3_cycles", n, 4092);
        chk("epoch3_ones", ones, 512);
        bad = 0;
        for (int i = 0; i < 1023; i++) if (cur_seq[i] !== prev_seq[i]) bad++;
        chk("epoch3_repeat", bad, 0);

        // Single slip mid-epoch
        repeat (401) @(negedge clk);
        slip = 1'b1;
        @(negedge clk);
        slip = 1'b0;
        chk("slip_busy_set", slip_busy, 1);
        @(negedge clk);
        chk("slip_busy_strobe", slip_busy, 1);
        chk("slip_strobe", chip_strobe, 1);
        @(negedge clk);
        chk("slip_busy_clr", slip_busy, 0);
        chk("slip_hold_idx", chip_index, 100);
        repeat (3) @(negedge clk);
        chk("slip_hold_idx2", chip_index, 100);
        @(negedge clk);
        chk("slip_next_idx", chip_index, 101);
        wait_cap(408, n);
        chk("slip_epoch", n, 4096);
        wait_cap(0, n);
        chk("post_slip_epoch", n, 4092);

        // Three slip requests within one chip
        slip = 1'b1;
        repeat (3) @(negedge clk);
        slip = 1'b0;
        wait_cap(3, n);
        chk("multi_slip_epoch", n, 4096);

        // Enable gap of 50 cycles mid-chip
        repeat (2) @(negedge clk);
        enable = 1'b0;
        f_code = code;
        f_idx = chip_index;
        f_ep = epoch_count;
        f_sb = slip_busy;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (code !== f_code || chip_index !== f_idx || epoch_count !== f_ep ||
                slip_busy !== f_sb || chip_strobe !== 1'b0 || capture !== 1'b0) bad++;
        end
        chk("freeze", bad, 0);
        enable = 1'b1;
        wait_cap(52, n);
        chk("gap_epoch", n, 4142);

        // Restart with slip at chip 500
        repeat (2001) @(negedge clk);
        chk("pre_restart_idx", chip_index, 500);
        restart = 1'b1;
        slip = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        slip = 1'b0;
        chk("rs_capture", capture, 1);
        chk("rs_index", chip_index, 0);
        chk("rs_epoch", epoch_count, 0);
        chk("rs_code", code, 1);
        chk("rs_slip_busy", slip_busy, 0);
        wait_cap(0, n);
        chk("rs_epoch_cycles", n, 4092);
        chk("rs_epoch_count", epoch_count, 1);

        // Asynchronous reset while capture is high
        #2;
        rst = 1'b0;
        #1;
        chk("arst_capture", capture, 0);
        chk("arst_index", chip_index, 0);
        chk("arst_epoch", epoch_count, 0);
        chk("arst_code", code, 1);
        chk("arst_slip_busy", slip_busy, 0);
        @(negedge clk);
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
